snitch_wb_arbiter: RTL

Writeback stage directly upstream of the integer register file write port. It merges single-cycle ALU results and variable-latency LSU load responses into one registered write port. LSU responses are buffered in a small FIFO. A per-register scoreboard of outstanding loads feeds the issue stage's operand hazard check.

---
 rtl/snitch_wb_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/snitch_wb_arbiter.sv
// Writeback arbiter: merges ALU results and buffered LSU load responses into one
// registered register-file write port, and tracks registers with outstanding loads.
module snitch_wb_arbiter #(
   parameter int unsigned  DataWidth   = 32,
   parameter int unsigned  AddrWidth   = 5,
   parameter int unsigned  LsuDepth    = 2,
   parameter bit           ZeroRegZero = 1'b1,
   localparam int unsigned NumWords    = 2 ** AddrWidth,
   localparam int unsigned CntWidth    = $clog2(LsuDepth + 1)
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        alu_valid_i,
   output logic                        alu_ready_o,
   input  logic [AddrWidth-1:0]        alu_rd_i,
   input  logic [DataWidth-1:0]        alu_data_i,
   input  logic                        lsu_valid_i,
   output logic                        lsu_ready_o,
   input  logic [AddrWidth-1:0]        lsu_rd_i,
   input  logic [DataWidth-1:0]        lsu_data_i,
   input  logic                        issue_valid_i,
   input  logic [AddrWidth-1:0]        issue_rd_i,
   input  logic [1:0][AddrWidth-1:0]   chk_addr_i,
   output logic [1:0]                  chk_busy_o,
   output logic                        we_o,
   output logic [AddrWidth-1:0]        waddr_o,
   output logic [DataWidth-1:0]        wdata_o,
   output logic [CntWidth-1:0]         lsu_cnt_o
);

   localparam int unsigned PtrWidth = (LsuDepth > 1) ? $clog2(LsuDepth) : 1;

   logic [AddrWidth-1:0] fifo_rd_q   [LsuDepth];
   logic [DataWidth-1:0] fifo_data_q [LsuDepth];
   logic [PtrWidth-1:0]  rd_ptr_q, wr_ptr_q;
   logic [CntWidth-1:0]  cnt_q;
   logic [NumWords-1:0]  busy_q, busy_d;

   logic                 fifo_full, fifo_empty;
   logic                 push, pop, alu_fire, win_valid;
   logic [AddrWidth-1:0] head_rd, win_rd;
   logic [DataWidth-1:0] head_data, win_data;

   function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
      if (p == PtrWidth'(LsuDepth - 1)) return '0;
      return p + PtrWidth'(1);
   endfunction

   function automatic logic is_zero_reg(input logic [AddrWidth-1:0] rd);
      return ZeroRegZero && (rd == '0);
   endfunction

   assign fifo_full  = (cnt_q == CntWidth'(LsuDepth));
   assign fifo_empty = (cnt_q == '0);
   assign head_rd    = fifo_rd_q[rd_ptr_q];
   assign head_data  = fifo_data_q[rd_ptr_q];

   // A full FIFO takes priority so load responses can never be starved indefinitely.
   assign alu_fire    = alu_valid_i && !fifo_full;
   assign pop         = !fifo_empty && !alu_fire;
   assign push        = lsu_valid_i && !fifo_full;
   assign win_valid   = alu_fire || pop;
   assign win_rd      = alu_fire ? alu_rd_i   : head_rd;
   assign win_data    = alu_fire ? alu_data_i : head_data;

   assign alu_ready_o = !(fifo_full && alu_valid_i);
   assign lsu_ready_o = !fifo_full;
   assign lsu_cnt_o   = cnt_q;
   assign chk_busy_o[0] = busy_q[chk_addr_i[0]];
   assign chk_busy_o[1] = busy_q[chk_addr_i[1]];

   // Issue is applied after the pop clear so a same-edge set wins.
   always_comb begin
      busy_d = busy_q;
      if (pop) busy_d[head_rd] = 1'b0;
      if (issue_valid_i && !is_zero_reg(issue_rd_i)) busy_d[issue_rd_i] = 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
         busy_q   <= '0;
         we_o     <= 1'b0;
         waddr_o  <= '0;
         wdata_o  <= '0;
      end else begin
         if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         if (push && !pop)      cnt_q <= cnt_q + CntWidth'(1);
         else if (pop && !push) cnt_q <= cnt_q - CntWidth'(1);
         busy_q <= busy_d;
         we_o   <= win_valid && !is_zero_reg(win_rd);
         if (win_valid) begin
            waddr_o <= win_rd;
            wdata_o <= win_data;
         end
      end
   end

   // Payload storage carries no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_rd_q[wr_ptr_q]   <= lsu_rd_i;
         fifo_data_q[wr_ptr_q] <= lsu_data_i;
      end
   end

   always @(posedge clk_i) begin
      if (rst_ni) begin
         assert (!(issue_valid_i && busy_q[issue_rd_i] && !(pop && head_rd == issue_rd_i)));
         assert (!(alu_fire && busy_q[alu_rd_i]));
         assert (!(push && !busy_q[lsu_rd_i] && !is_zero_reg(lsu_rd_i)));
      end
   end

endmodule
